cam_alloc_ctrl: RTL

Key-management front end for the shift-register CAM. It accepts insert/delete commands keyed by data value and tracks which CAM entries are occupied. It finds duplicates and victims through the CAM compare port, picks the lowest free entry for inserts, and drives the CAM write port through its busy handshake. It sits between the lookup-table software/command path and the CAM. It returns one status response per command.

---
 rtl/cam_alloc_ctrl_if.sv | 32 +++
 rtl/cam_alloc_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/cam_alloc_ctrl_if.sv
// Command/response channel of the CAM allocation controller.
// master : command source (drives cmd_data/cmd_delete/cmd_valid, sees cmd_ready and rsp_*)
// slave  : controller side (sees the command, drives cmd_ready and rsp_*)
//   cmd_data   DATA_WIDTH  key
//   cmd_delete 1           1 = delete, 0 = insert
//   cmd_valid  1           command valid
//   cmd_ready  1           command accepted when cmd_valid && cmd_ready
//   rsp_addr   ADDR_WIDTH  entry written, deleted or found
//   rsp_status 2           0 OK, 1 DUP, 2 FULL, 3 NOTFOUND
//   rsp_valid  1           one-cycle response pulse, no backpressure
interface cam_alloc_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 5
);
    logic [DATA_WIDTH-1:0] cmd_data;
    logic                  cmd_delete;
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [ADDR_WIDTH-1:0] rsp_addr;
    logic [1:0]            rsp_status;
    logic                  rsp_valid;

    modport master (
        output cmd_data, cmd_delete, cmd_valid,
        input  cmd_ready, rsp_addr, rsp_status, rsp_valid
    );

    modport slave (
        input  cmd_data, cmd_delete, cmd_valid,
        output cmd_ready, rsp_addr, rsp_status, rsp_valid
    );
endinterface

// File: rtl/cam_alloc_ctrl.sv
// Key-management front end for the shift-register CAM: accepts insert/delete
// commands, tracks entry occupancy, detects duplicates/victims through the CAM
// compare port, allocates the lowest free entry and drives the CAM write port
// through its busy handshake. One response per accepted command.
//
// Build option: CAM_ALLOC_DUP_CHECK_EN
//   defined   : inserts look the key up first and answer DUP on a hit
//   undefined : inserts skip the lookup; duplicate keys may occupy several entries
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   cmd               command/response channel (cam_alloc_ctrl_if.slave)
//   cam_compare_data  key to CAM compare port
//   cam_match(_addr)  CAM compare result, registered one cycle after compare
//   cam_write_*       CAM write port (addr/data/delete/enable), busy from CAM
//   used_count        occupied entries; full / empty flags
module cam_alloc_ctrl #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    cam_alloc_ctrl_if.slave       cmd,
    output logic [DATA_WIDTH-1:0] cam_compare_data,
    input  logic                  cam_match,
    input  logic [ADDR_WIDTH-1:0] cam_match_addr,
    output logic [ADDR_WIDTH-1:0] cam_write_addr,
    output logic [DATA_WIDTH-1:0] cam_write_data,
    output logic                  cam_write_delete,
    output logic                  cam_write_enable,
    input  logic                  cam_write_busy,
    output logic [ADDR_WIDTH:0]   used_count,
    output logic                  full,
    output logic                  empty
);

    localparam int unsigned ENTRIES = 2 ** ADDR_WIDTH;
    localparam int unsigned CW      = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(ENTRIES);

    localparam logic [1:0] ST_OK       = 2'd0;
    localparam logic [1:0] ST_DUP      = 2'd1;
    localparam logic [1:0] ST_FULL     = 2'd2;
    localparam logic [1:0] ST_NOTFOUND = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_CHECK,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] key_q;
    logic                  op_q;
    logic [ENTRIES-1:0]    valid_map;
    logic [ADDR_WIDTH-1:0] free_addr;
    logic [CW-1:0]         cnt_inc;
    logic [CW-1:0]         cnt_dec;

    // The CAM always compares against the held key; writes use the same key.
    assign cam_compare_data = key_q;
    assign cam_write_data   = key_q;

    // Only IDLE accepts, and never while the CAM is still busy (init or write).
    assign cmd.cmd_ready = (state == S_IDLE) && !cam_write_busy;

    assign cnt_inc = used_count + CW'(1);
    assign cnt_dec = used_count - CW'(1);

    // Lowest-index free entry; descending scan so the lowest hit wins.
    always_comb begin
        free_addr = '0;
        for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
            if (!valid_map[i]) begin
                free_addr = ADDR_WIDTH'(i);
            end
        end
    end

    // Controller FSM with registered outputs and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= S_IDLE;
            key_q            <= '0;
            op_q             <= 1'b0;
            valid_map        <= '0;
            used_count       <= '0;
            full             <= 1'b0;
            empty            <= 1'b1;
            cam_write_addr   <= '0;
            cam_write_delete <= 1'b0;
            cam_write_enable <= 1'b0;
            cmd.rsp_valid    <= 1'b0;
            cmd.rsp_addr     <= '0;
            cmd.rsp_status   <= ST_OK;
        end else begin
            cam_write_enable <= 1'b0;
            cmd.rsp_valid    <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (cmd.cmd_valid && !cam_write_busy) begin
                        key_q <= cmd.cmd_data;
                        op_q  <= cmd.cmd_delete;
`ifdef CAM_ALLOC_DUP_CHECK_EN
                        state <= S_LOOKUP;
`else
                        // Inserts go straight to allocation; deletes still need the lookup.
                        if (cmd.cmd_delete) begin
                            state <= S_LOOKUP;
                        end else if (full) begin
                            cmd.rsp_valid  <= 1'b1;
                            cmd.rsp_status <= ST_FULL;
                            cmd.rsp_addr   <= '0;
                            state          <= S_RESP;
                        end else begin
                            cam_write_enable     <= 1'b1;
                            cam_write_addr       <= free_addr;
                            cam_write_delete     <= 1'b0;
                            valid_map[free_addr] <= 1'b1;
                            used_count           <= cnt_inc;
                            full                 <= (cnt_inc == FULL_COUNT);
                            empty                <= 1'b0;
                            state                <= S_ISSUE;
                        end
`endif
                    end
                end

                // CAM registers the compare result for key_q during this cycle.
                S_LOOKUP: state <= S_CHECK;

                S_CHECK: begin
                    if (!op_q) begin
                        if (cam_match) begin
                            cmd.rsp_valid  <= 1'b1;
                            cmd.rsp_status <= ST_DUP;
                            cmd.rsp_addr   <= cam_match_addr;
                            state          <= S_RESP;
                        end else if (full) begin
                            cmd.rsp_valid  <= 1'b1;
                            cmd.rsp_status <= ST_FULL;
                            cmd.rsp_addr   <= '0;
                            state          <= S_RESP;
                        end else begin
                            cam_write_enable     <= 1'b1;
                            cam_write_addr       <= free_addr;
                            cam_write_delete     <= 1'b0;
                            valid_map[free_addr] <= 1'b1;
                            used_count           <= cnt_inc;
                            full                 <= (cnt_inc == FULL_COUNT);
                            empty                <= 1'b0;
                            state                <= S_ISSUE;
                        end
                    end else begin
                        if (!cam_match) begin
                            cmd.rsp_valid  <= 1'b1;
                            cmd.rsp_status <= ST_NOTFOUND;
                            cmd.rsp_addr   <= '0;
                            state          <= S_RESP;
                        end else begin
                            cam_write_enable          <= 1'b1;
                            cam_write_addr            <= cam_match_addr;
                            cam_write_delete          <= 1'b1;
                            valid_map[cam_match_addr] <= 1'b0;
                            used_count                <= cnt_dec;
                            full                      <= 1'b0;
                            empty                     <= (cnt_dec == '0);
                            state                     <= S_ISSUE;
                        end
                    end
                end

                // Write enable is high for this single cycle; addr/delete hold until RESP.
                S_ISSUE: state <= S_WAIT;

                S_WAIT: begin
                    if (!cam_write_busy) begin
                        cmd.rsp_valid  <= 1'b1;
                        cmd.rsp_status <= ST_OK;
                        cmd.rsp_addr   <= cam_write_addr;
                        state          <= S_RESP;
                    end
                end

                S_RESP: state <= S_IDLE;

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
